ram_arbiter: RTL

Two-port arbiter that shares the single 8-bit program/data RAM between the CPU core (port 0) and a loader/debug master (port 1). Port 1 is the switch/UART program loader or the debug monitor. The arbiter serialises whole transactions, drives the RAM address, data and write-enable lines, and returns read data with a one-cycle acknowledge. It sits between the CPU's memory bus and the RAM, all in the clk_qzt domain.

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_if.sv | 52 +++++
 rtl/ram_arbiter_rr_pick2.sv | 24 ++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port indices
// and the legal read-latency window.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Counter only has to reach RD_LAT_MAX.
    localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

    // Keeps an out-of-range parameter from producing a counter that never matches.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between CPU port 0, loader port 1, the arbiter and the shared RAM.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          p1_lock;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    logic          cpu_hold;
    logic          owner;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output p1_ack, p1_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata,
        output cpu_hold, owner
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  p1_ack, p1_rdata,
        input  cpu_hold, owner
    );

    modport mem (
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; the lock input masks port 0.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       lock,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic [1:0] req_eff;

    always_comb begin
        req_eff     = {req[1], req[0] & ~lock};
        grant_valid = |req_eff;
        if (req_eff == 2'b11) begin
            grant_idx = ~last_owner;
        end else begin
            grant_idx = req_eff[1] ? PORT_LDR : PORT_CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises whole CPU/loader transactions onto the single program/data RAM.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | sample requests, grant one (round-robin on tie, lock masks p0)
//   ST_ACCESS | RAM lines driven; write lasts one cycle, read waits RD_LAT
//   ST_DONE   | owner's ack high for one cycle, last_owner updated
module ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_qzt,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    localparam int              LAT   = clamp_rd_lat(RD_LAT);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_owner_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             ram_we_q;
    logic             p0_ack_q;
    logic             p1_ack_q;
    logic [DW-1:0]    p0_rdata_q;
    logic [DW-1:0]    p1_rdata_q;
    logic             cpu_hold_q;

    logic             grant_valid;
    logic             grant_idx;
    logic             do_grant;
    logic             do_capture;
    logic             do_finish;
    logic             ack_set;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             hold_owner;

    rr_pick2 u_pick (
        .req         ({bus.p1_req, bus.p0_req}),
        .last_owner  (last_owner_q),
        .lock        (bus.p1_lock),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_we    = grant_idx ? bus.p1_we    : bus.p0_we;
        sel_addr  = grant_idx ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = grant_idx ? bus.p1_wdata : bus.p0_wdata;
    end

    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    do_grant = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == LAT_C) begin
                    do_capture = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                do_finish = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ack_set    = (state_q == ST_ACCESS) && (state_d == ST_DONE);
        hold_owner = do_grant ? grant_idx : owner_q;
    end

    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            cnt_q        <= '0;
            owner_q      <= PORT_CPU;
            last_owner_q <= PORT_LDR;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ram_we_q     <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            cpu_hold_q   <= 1'b0;
        end else begin
            // Write strobe exists only in the single cycle after the grant.
            ram_we_q <= do_grant & sel_we;
            if (do_grant) begin
                owner_q <= grant_idx;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                cnt_q   <= '0;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (do_capture) begin
                if (owner_q == PORT_LDR) begin
                    p1_rdata_q <= bus.ram_rdata;
                end else begin
                    p0_rdata_q <= bus.ram_rdata;
                end
            end
            p0_ack_q <= ack_set && (owner_q == PORT_CPU);
            p1_ack_q <= ack_set && (owner_q == PORT_LDR);
            if (do_finish) begin
                last_owner_q <= owner_q;
            end
            cpu_hold_q <= ((state_d != ST_IDLE) && (hold_owner == PORT_LDR)) | bus.p1_lock;
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.p0_ack    = p0_ack_q;
    assign bus.p1_ack    = p1_ack_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.owner     = owner_q;

endmodule
